i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-low: the block is in reset when rst=0 at a clk rising edge.
REQ-003 sck  input  1  I2S bit clock from the external transmitter; asynchronous to clk; frequency no more than clk/4.
REQ-004 ws  input  1  I2S word select: 0 = left slot, 1 = right slot; asynchronous.
REQ-005 sd  input  1  I2S serial data, MSB first; asynchronous.
REQ-006 sample_size  input  4  word length code: 0 = 8 bit, 1 = 12 bit, 3 = 16 bit, 4 = 32 bit; any other code = 16 bit.
REQ-007 sample_left  output  32  last complete left word, right-justified, zero-extended.
REQ-008 sample_right  output  32  last complete right word, right-justified, zero-extended.
REQ-009 valid  output  1  one-clk pulse when a complete left/right pair has been updated.
REQ-010 frame_err  output  1  one-clk pulse when a channel slot ends short of N bits.
REQ-011 busy  output  1  high while a frame is being received (any state other than IDLE).

Function
REQ-012 sck, ws and sd shall each pass through a 2-flop synchronizer; an sck rising edge is detected by comparing sync stage 2 against a third registered stage.
REQ-013 All sampling shall occur only in the clk cycle flagged by a detected sck rising edge; ws and sd values used are the synchronized values in that cycle.
REQ-014 N = word length from sample_size, latched at each ws falling edge (start of frame); mid-frame changes are ignored until the next frame.
REQ-015 States: IDLE, DELAY, SHIFT, HOLD; the state advances only on detected sck rising edges, except for reset.
REQ-016 IDLE: wait for a ws transition 1->0 (between consecutive sck edges); then go to DELAY with channel = left.
REQ-017 DELAY: the one-bit I2S delay; discard sd on this edge; go to SHIFT with bit counter = 0 and shift register cleared.
REQ-018 SHIFT: shift sd into the LSB of the 32-bit shift register and increment the counter; when the counter reaches N, write the word to a channel holding register and go to HOLD.
REQ-019 HOLD: ignore sd; on a ws transition, toggle the channel and go to DELAY.
REQ-020 In SHIFT, a ws transition before N bits shall:
- discard the partial word;
- pulse frame_err on the next clk;
- toggle the channel and go to DELAY (the new slot's MSB follows one bit later, per I2S).
REQ-021 ws changing while in DELAY shall be treated as a short slot (per REQ-020).
REQ-022 Once the right word completes, with a left word completed earlier in the same frame:
- sample_left and sample_right shall both update in the same clk;
- valid shall pulse in the clk immediately after.
REQ-023 A frame whose left word failed shall not update the outputs or pulse valid; sample_left and sample_right always form a matched pair.
REQ-024 Outputs hold their values between updates; valid and frame_err are never high for more than one clk per event.
REQ-025 Latency: valid shall assert no more than 5 clk cycles after the external sck rising edge carrying the right word's LSB.
REQ-026 Excess bits beyond N within a slot shall be ignored (HOLD).

Reset
REQ-027 When rst=0 at a clk edge:
- state = IDLE, counter = 0, shift register = 0;
- synchronizer flops = 0;
- sample_left = sample_right = 0;
- valid = frame_err = busy = 0.
REQ-028 Reset mid-frame shall discard all partial data; after release, reception resumes only at the next ws falling edge.

Verification
REQ-029 sample_size=0, left=145 (0x91), right=145, continuous frames -> sample_left=0x00000091, sample_right=0x00000091, valid pulses once per frame.
REQ-030 sample_size=3, left=0xA5C3, right=0x1234 -> sample_left=0x0000A5C3, sample_right=0x00001234, both updated in the same clk.
REQ-031 sample_size=4, left=0xDEADBEEF, right=0x80000001, clk=4x sck -> exact values, valid no more than 5 clk after the last sck edge.
REQ-032 Stream started mid right slot -> no valid or frame_err until after the first full frame following a ws falling edge.
REQ-033 sample_size=3, ws toggled after 10 bits of the left slot -> one frame_err pulse, outputs unchanged, no valid for that frame, the next good frame is received correctly.
REQ-034 rst=0 for 2 clk during right-slot shifting -> all outputs 0; the next complete frame is received correctly.

Source files
------------

// File: rtl/i2s_receiver.sv
// I2S receiver: synchronises sck/ws/sd into the clk domain, deserialises left/right
// words of a selectable length and presents them as a matched pair with a valid pulse.
`timescale 1ns/1ps
module i2s_receiver (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ws,
  input  logic        sd,
  input  logic [3:0]  sample_size,
  output logic [31:0] sample_left,
  output logic [31:0] sample_right,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, HOLD} state_t;

  state_t      state, state_next;
  logic [2:0]  sck_sync;
  logic [1:0]  ws_sync, sd_sync;
  logic        ws_prev;
  logic [5:0]  n_bits, n_sel, cnt;
  logic [31:0] shreg, left_hold, word;
  logic        chan;
  logic        left_ok, pair_done;
  logic        sck_rise, ws_edge, ws_fall, last_bit;
  logic        do_start, do_toggle, do_clear, do_shift, do_store, do_err;

  // ws is compared against its value at the previous sck edge, so a
  // transition is seen exactly once, on the first edge carrying the new level
  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign ws_edge  = sck_rise & (ws_sync[1] != ws_prev);
  assign ws_fall  = ws_edge & ~ws_sync[1];
  assign last_bit = (cnt + 6'd1) == n_bits;
  assign word     = {shreg[30:0], sd_sync[1]};
  assign busy     = (state != IDLE);

  always_comb begin
    case (sample_size)
      4'd0:    n_sel = 6'd8;
      4'd1:    n_sel = 6'd12;
      4'd4:    n_sel = 6'd32;
      default: n_sel = 6'd16;
    endcase
  end

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_toggle  = 1'b0;
    do_clear   = 1'b0;
    do_shift   = 1'b0;
    do_store   = 1'b0;
    do_err     = 1'b0;
    if (sck_rise) begin
      case (state)
        IDLE: if (ws_fall) begin
          state_next = DELAY;
          do_start   = 1'b1;
        end
        DELAY: if (ws_edge) begin
          do_err    = 1'b1;
          do_toggle = 1'b1;
        end else begin
          state_next = SHIFT;
          do_clear   = 1'b1;
        end
        SHIFT: if (ws_edge) begin
          do_err     = 1'b1;
          do_toggle  = 1'b1;
          state_next = DELAY;
        end else begin
          do_shift = 1'b1;
          if (last_bit) begin
            do_store   = 1'b1;
            state_next = HOLD;
          end
        end
        HOLD: if (ws_edge) begin
          do_toggle  = 1'b1;
          state_next = DELAY;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync     <= '0;
      ws_sync      <= '0;
      sd_sync      <= '0;
      ws_prev      <= 1'b0;
      n_bits       <= 6'd16;
      cnt          <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      chan         <= 1'b0;
      left_ok      <= 1'b0;
      pair_done    <= 1'b0;
      sample_left  <= '0;
      sample_right <= '0;
      valid        <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck};
      ws_sync   <= {ws_sync[0], ws};
      sd_sync   <= {sd_sync[0], sd};
      frame_err <= do_err;
      pair_done <= 1'b0;
      valid     <= pair_done;
      if (sck_rise) ws_prev <= ws_sync[1];
      // a ws falling edge opens a new frame: any earlier left word is stale
      if (ws_fall) begin
        n_bits  <= n_sel;
        left_ok <= 1'b0;
      end
      if (do_start)  chan <= 1'b0;
      if (do_toggle) chan <= ~chan;
      if (do_clear) begin
        cnt   <= '0;
        shreg <= '0;
      end
      if (do_shift) begin
        shreg <= word;
        cnt   <= cnt + 6'd1;
      end
      if (do_store) begin
        if (!chan) begin
          left_hold <= word;
          left_ok   <= 1'b1;
        end else if (left_ok) begin
          sample_left  <= left_hold;
          sample_right <= word;
          pair_done    <= 1'b1;
          left_ok      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: directed I2S frames push expected pairs,
// a negedge monitor pops them on valid and checks frame_err, latency and pairing.
`timescale 1ns/1ps
module tb_i2s_receiver;

  logic        clk, rst, sck, ws, sd;
  logic [3:0]  sample_size;
  logic [31:0] sample_left, sample_right;
  logic        valid, frame_err, busy;

  i2s_receiver dut (
    .clk(clk), .rst(rst), .sck(sck), .ws(ws), .sd(sd),
    .sample_size(sample_size),
    .sample_left(sample_left), .sample_right(sample_right),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  int          err_exp = 0;
  int          half = 40;
  logic [63:0] exp_q[$];
  logic [31:0] prev_l = '0, prev_r = '0;
  logic        upd_pending = 1'b0;
  logic        lat_check = 1'b0;
  longint      last_rise = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic send_bit(input logic w, input logic d);
    sck = 1'b0; ws = w; sd = d;
    #(half);
    sck = 1'b1; last_rise = $time;
    #(half);
  endtask

  // transition edge, one delay bit, n data bits MSB first, then ignored extras
  task automatic send_slot(input logic w, input logic [31:0] data, input int n, input int extra);
    send_bit(w, 1'b1);
    send_bit(w, 1'b1);
    for (int i = n - 1; i >= 0; i--) send_bit(w, data[i]);
    for (int i = 0; i < extra; i++) send_bit(w, 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int extra);
    send_slot(1'b0, l, n, extra);
    send_slot(1'b1, r, n, extra);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    longint lat;
    if (upd_pending) begin
      check("valid_after_update", valid, 1'b1);
      upd_pending = 1'b0;
    end
    if (rst === 1'b1 && (sample_left !== prev_l || sample_right !== prev_r)) begin
      check("both_samples_updated", {31'd0, sample_left !== prev_l, 31'd0, sample_right !== prev_r},
            {32'd1, 32'd1});
      check("valid_not_with_update", valid, 1'b0);
      upd_pending = 1'b1;
    end
    prev_l = sample_left;
    prev_r = sample_right;
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got left=%h right=%h, no pair expected at %0t",
                 sample_left, sample_right, $time);
      end else begin
        e = exp_q.pop_front();
        check("pair", {sample_left, sample_right}, e);
      end
      if (lat_check) begin
        lat = ($time - 5 - last_rise) / 10;
        checks++;
        if (lat <= 5) passes++;
        else $display("FAIL latency: got %0d clk required <= 5", lat);
        lat_check = 1'b0;
      end
    end
    if (frame_err === 1'b1) begin
      checks++;
      if (err_exp > 0) begin
        passes++;
        err_exp--;
      end else $display("FAIL unexpected_frame_err: got 1 required 0 at %0t", $time);
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; sck = 1'b0; ws = 1'b1; sd = 1'b0; sample_size = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_left",  sample_left,  32'd0);
    check("rst_right", sample_right, 32'd0);
    check("rst_valid", valid, 1'b0);
    check("rst_err",   frame_err, 1'b0);
    check("rst_busy",  busy, 1'b0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);

    // stream joined mid right slot, then three 8-bit frames back to back
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'(i));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({32'h0000_0091, 32'h0000_0091});
      send_frame(32'h91, 32'h91, 8, 1);
    end
    check("busy_in_frame", busy, 1'b1);

    sample_size = 4'd3;
    exp_q.push_back({32'h0000_A5C3, 32'h0000_1234});
    send_frame(32'hA5C3, 32'h1234, 16, 2);

    // 32-bit at clk = 4x sck, latency measured from the right LSB edge
    sample_size = 4'd4; half = 20;
    exp_q.push_back({32'hDEAD_BEEF, 32'h8000_0001});
    send_slot(1'b0, 32'hDEAD_BEEF, 32, 0);
    lat_check = 1'b1;
    send_slot(1'b1, 32'h8000_0001, 32, 0);
    repeat (10) @(negedge clk);
    check("latency_seen", lat_check, 1'b0);

    // short left slot: 10 of 16 bits
    sample_size = 4'd3; half = 40;
    err_exp++;
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'(i & 1));
    send_slot(1'b1, 32'h5555, 16, 1);
    repeat (10) @(negedge clk);
    check("err_hold_left",  sample_left,  32'hDEAD_BEEF);
    check("err_hold_right", sample_right, 32'h8000_0001);
    check("err_seen", err_exp, 0);
    exp_q.push_back({32'h0000_0F0F, 32'h0000_F0F0});
    send_frame(32'h0F0F, 32'hF0F0, 16, 1);

    // reset during right-slot shifting
    send_slot(1'b0, 32'h1111, 16, 1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst2_left",  sample_left,  32'd0);
    check("rst2_right", sample_right, 32'd0);
    check("rst2_valid", valid, 1'b0);
    check("rst2_busy",  busy, 1'b0);
    for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b1);
    exp_q.push_back({32'h0000_1357, 32'h0000_2468});
    send_frame(32'h1357, 32'h2468, 16, 1);

    repeat (20) @(negedge clk);
    check("missing_valid", exp_q.size(), 0);
    check("missing_frame_err", err_exp, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
